alu_req_scheduler: RTL
======================

# alu_req_scheduler

Shares one 8-bit ALU datapath among four requesters. The block round-robin arbitrates, latches the winner's 4-bit opcode and operands, and drives the ALU with a one-hot 16-bit operation select (the 4-to-16 decode of the opcode). It waits a fixed ALU latency, captures result and flags, and returns them with the requester ID over a valid/ready response channel. It sits between the requesting units and the ALU core.

## Interface
- DATA_W, 8, operand and result width
- ALU_LAT, 2, cycles from operand issue to valid ALU_RESULT; legal range 1..15
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  4  request valid, bit i = requester i
- REQ_READY  out  4  grant; at most one bit high; transfer when REQ_VALID[i] & REQ_READY[i]
- REQ_OP  in  16  requester i opcode at [4i+3:4i]
- REQ_A  in  4*DATA_W  requester i operand A at [DATA_W*i +: DATA_W]
- REQ_B  in  4*DATA_W  requester i operand B, same packing
- ALU_EN  out  1  ALU operation in progress
- ALU_SEL  out  16  one-hot op select, bit n set for opcode n
- ALU_A, ALU_B  out  DATA_W  operands to ALU
- ALU_RESULT  in  DATA_W  ALU result
- ALU_FLAGS  in  4  {carry, zero, negative, overflow}
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response accepted
- RSP_ID  out  2  index of requester that issued the op
- RSP_DATA  out  DATA_W  captured result
- RSP_FLAGS  out  4  captured flags
- BUSY  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Pointer PRIO (2 bits), down-counter CNT (4 bits).
- IDLE: search REQ_VALID starting at PRIO and incrementing mod 4. The first valid index i wins. REQ_READY = one-hot(i), combinational from REQ_VALID; REQ_READY = 0 if no request is valid. On the transfer edge the block latches REQ_OP/A/B[i] and ID=i, sets PRIO <= i+1 mod 4 and CNT <= ALU_LAT-1, and moves to EXEC.
- EXEC: ALU_EN=1, ALU_SEL = 16'h1 << op, ALU_A/ALU_B = latched operands, all stable for the whole state. CNT decrements each cycle. On the edge where CNT==0, capture ALU_RESULT and ALU_FLAGS into RSP_DATA/RSP_FLAGS and move to RESP.
- RESP: RSP_VALID=1. RSP_ID, RSP_DATA and RSP_FLAGS are held stable until RSP_VALID & RSP_READY, then the FSM returns to IDLE. No grant is issued in the RESP cycle.
- Outside EXEC: ALU_EN=0, ALU_SEL=0, ALU_A=ALU_B=0.
- REQ_READY is 0 in EXEC and RESP. Requests are not queued; a requester holds REQ_VALID until granted.
- A requester dropping REQ_VALID before it is granted is legal; no grant is issued to it.
- Reset, at power-up or mid-operation: state IDLE, PRIO=0, CNT=0, all outputs 0, and REQ_READY forced 0 while RST=1. An in-flight op is discarded and produces no response.

## Timing
- Grant at edge T (IDLE cycle).
- EXEC occupies cycles T+1 .. T+ALU_LAT. ALU_RESULT is sampled at the end of cycle T+ALU_LAT.
- RSP_VALID first high in cycle T+ALU_LAT+1.
- With RSP_READY held high, RESP lasts 1 cycle and the next grant occurs ALU_LAT+2 cycles after the previous one.
- The first grant after RST deasserts can occur in the first cycle with RST=0.
- ALU_LAT=1: EXEC is a single cycle (CNT loads 0).

## Test plan
- Reset: RST=1 for 2 cycles with REQ_VALID=4'hF -> REQ_READY=0, ALU_SEL=0, RSP_VALID=0, BUSY=0. First cycle after release: REQ_READY=4'b0001.
- Single op: ALU_LAT=2; requester 2 sends op=4'h3, A=8'h12, B=8'h34; ALU model returns A+B -> REQ_READY=4'b0100 for one cycle, then ALU_SEL=16'h0008 and ALU_EN=1 for exactly 2 cycles, then RSP_VALID with RSP_ID=2 and RSP_DATA=8'h46, RSP_FLAGS zero=0.
- Round-robin: REQ_VALID=4'hF held, RSP_READY=1, ALU_LAT=2 -> grant order 0,1,2,3,0 with grants exactly 4 cycles apart.
- Backpressure: RSP_READY=0 for 5 cycles in RESP -> RSP_VALID, RSP_ID and RSP_DATA stable, REQ_READY=0 throughout. After RSP_READY=1 for one cycle, FSM in IDLE the next cycle.
- Decode sweep: opcodes 4'h0..4'hF from requester 0 -> ALU_SEL = 16'h0001..16'h8000, exactly one bit set during EXEC.
- Reset mid-EXEC: assert RST in the second EXEC cycle -> next cycle IDLE, no RSP_VALID ever produced for that op, and the next grant goes to requester 0.

Source files
------------

// File: rtl/alu_req_scheduler.sv
// Purpose : round-robin scheduler sharing one ALU among four requesters; returns result+flags with requester ID.
// Latency : grant -> ALU_LAT EXEC cycles -> response valid at grant+ALU_LAT+1; back-to-back grants every ALU_LAT+2 cycles.
// Backpres: one op in flight; no grants while EXEC/RESP; response held stable until RSP_READY.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQ_VALID/REQ_READY      per-requester handshake (READY is a one-hot grant)
//   REQ_OP/REQ_A/REQ_B       packed per-requester opcode and operands
//   ALU_EN/ALU_SEL/ALU_A/B   drive to the ALU core (zero outside EXEC)
//   ALU_RESULT/ALU_FLAGS     ALU return, sampled on the last EXEC cycle
//   RSP_*                    response channel with captured ID, data, flags
//   BUSY                     high whenever the FSM is not idle
module alu_req_scheduler #(
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          REQ_VALID,
    output logic [3:0]          REQ_READY,
    input  logic [15:0]         REQ_OP,
    input  logic [4*DATA_W-1:0] REQ_A,
    input  logic [4*DATA_W-1:0] REQ_B,
    output logic                ALU_EN,
    output logic [15:0]         ALU_SEL,
    output logic [DATA_W-1:0]   ALU_A,
    output logic [DATA_W-1:0]   ALU_B,
    input  logic [DATA_W-1:0]   ALU_RESULT,
    input  logic [3:0]          ALU_FLAGS,
    output logic                RSP_VALID,
    input  logic                RSP_READY,
    output logic [1:0]          RSP_ID,
    output logic [DATA_W-1:0]   RSP_DATA,
    output logic [3:0]          RSP_FLAGS,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // EXEC runs for ALU_LAT cycles, leaving on the cycle the counter reads zero.
    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          prio_q;
    logic [3:0]          cnt_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [1:0]          id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [3:0]          rsp_flags_q;

    logic                grant_found;
    logic [1:0]          grant_idx;
    logic [1:0]          cand;
    logic [3:0]          sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                take;

    // Rotating priority search: first valid requester at or after prio_q wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = prio_q;
        cand        = prio_q;
        for (int k = 0; k < 4; k++) begin
            cand = prio_q + 2'(k);
            if (!grant_found && REQ_VALID[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Select the winner's opcode and operands out of the packed request buses.
    always_comb begin
        sel_op = 4'd0;
        sel_a  = '0;
        sel_b  = '0;
        for (int k = 0; k < 4; k++) begin
            if (grant_idx == 2'(k)) begin
                sel_op = REQ_OP[4*k +: 4];
                sel_a  = REQ_A[DATA_W*k +: DATA_W];
                sel_b  = REQ_B[DATA_W*k +: DATA_W];
            end
        end
    end

    // The grant is only asserted toward a valid requester, so a grant is a transfer.
    assign take = (state_q == IDLE) && grant_found && !RST;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found)    state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0)  state_d = RESP;
            RESP:    if (RSP_READY)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        REQ_READY = 4'd0;
        ALU_EN    = 1'b0;
        ALU_SEL   = 16'd0;
        ALU_A     = '0;
        ALU_B     = '0;
        RSP_VALID = 1'b0;
        BUSY      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (take) begin
                    REQ_READY = 4'b0001 << grant_idx;
                end
            end
            EXEC: begin
                ALU_EN  = 1'b1;
                ALU_SEL = 16'h0001 << op_q;
                ALU_A   = a_q;
                ALU_B   = b_q;
            end
            RESP: begin
                RSP_VALID = 1'b1;
            end
            default: ;
        endcase
    end

    assign RSP_ID    = id_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_FLAGS = rsp_flags_q;

    // Datapath: request latch, priority pointer, latency counter, result capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prio_q      <= 2'd0;
            cnt_q       <= 4'd0;
            op_q        <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 2'd0;
            rsp_data_q  <= '0;
            rsp_flags_q <= 4'd0;
        end else begin
            if (take) begin
                op_q   <= sel_op;
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= grant_idx;
                prio_q <= grant_idx + 2'd1;
                cnt_q  <= CNT_INIT;
            end
            if (state_q == EXEC) begin
                if (cnt_q == 4'd0) begin
                    rsp_data_q  <= ALU_RESULT;
                    rsp_flags_q <= ALU_FLAGS;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

endmodule
